// File: rtl/obi_wb_bridge.sv
// Single-outstanding bridge from a req/gnt/rvalid core memory port to a Wishbone-classic master.
// Captures the request on grant, holds the bus until ack/err or timeout, then returns one response.
module obi_wb_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit REG_RESP       = 1'b1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [ADDR_WIDTH-1:0]     addr_i,
    input  logic                      we_i,
    input  logic [DATA_WIDTH/8-1:0]   be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      err_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [DATA_WIDTH/8-1:0]   wstrb_o,
    output logic [ADDR_WIDTH-1:0]     addr_o,
    output logic [DATA_WIDTH-1:0]     data_o,
    input  logic [DATA_WIDTH-1:0]     data_i,
    input  logic                      ack_i,
    input  logic                      err_i,
    output logic                      busy_o,
    output logic                      timeout_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_we;
    logic [BE_W-1:0]       r_be;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_tmo;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_gnt;
    logic                  w_term;
    logic                  w_tmo_hit;

    // Grant is combinational from req; reset must mask it because the state alone cannot.
    assign w_gnt     = rst_ni && req_i && (r_state != S_BUS);
    assign w_term    = (r_state == S_BUS) && (ack_i || err_i);
    assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_state == S_BUS) && !(ack_i || err_i)
                       && (r_cnt == CNT_LAST);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_gnt) w_next = S_BUS;
            S_BUS: begin
                if (w_term)         w_next = REG_RESP ? S_RESP : S_IDLE;
                else if (w_tmo_hit) w_next = S_RESP;
            end
            S_RESP:  w_next = w_gnt ? S_BUS : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_o     = w_gnt;
        busy_o    = (r_state != S_IDLE);
        cyc_o     = 1'b0;
        stb_o     = 1'b0;
        we_o      = 1'b0;
        wstrb_o   = '0;
        addr_o    = '0;
        data_o    = '0;
        rvalid_o  = 1'b0;
        rdata_o   = '0;
        err_o     = 1'b0;
        timeout_o = 1'b0;
        case (r_state)
            S_BUS: begin
                cyc_o   = 1'b1;
                stb_o   = 1'b1;
                we_o    = r_we;
                wstrb_o = r_be;
                addr_o  = r_addr;
                data_o  = r_wdata;
                if (!REG_RESP && w_term) begin
                    rvalid_o = 1'b1;
                    err_o    = err_i;
                    rdata_o  = (r_we || err_i) ? '0 : data_i;
                end
            end
            S_RESP: begin
                rvalid_o  = 1'b1;
                rdata_o   = r_rdata;
                err_o     = r_err;
                timeout_o = r_tmo;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_tmo   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            if (w_gnt) begin
                r_addr  <= addr_i;
                r_we    <= we_i;
                r_be    <= be_i;
                r_wdata <= wdata_i;
                r_cnt   <= '0;
            end else if ((r_state == S_BUS) && !w_term && (r_cnt != CNT_MAX)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // Error wins over ack, and write/error responses never carry bus data.
            if (w_term) begin
                r_rdata <= (r_we || err_i) ? '0 : data_i;
                r_err   <= err_i;
                r_tmo   <= 1'b0;
            end else if (w_tmo_hit) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
                r_tmo   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_wb_bridge.sv
// Bench for obi_wb_bridge: cycle vector table on a registered-response instance,
// plus hand sequences for async reset and the same-cycle-response instance.
module tb_obi_wb_bridge;
    logic        clk = 1'b0;
    logic        rst_ni;
    logic        req, we, ack, err;
    logic [3:0]  be;
    logic [31:0] addr, wdata, din;

    logic        a_gnt, a_rv, a_err, a_cyc, a_stb, a_we, a_busy, a_tmo;
    logic [3:0]  a_be;
    logic [31:0] a_rdata, a_addr, a_data;
    logic        b_gnt, b_rv, b_err, b_cyc, b_stb, b_we, b_busy, b_tmo;
    logic [3:0]  b_be;
    logic [31:0] b_rdata, b_addr, b_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .REG_RESP(1'b1)) u_a (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(a_gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(a_rv), .rdata_o(a_rdata), .err_o(a_err),
        .cyc_o(a_cyc), .stb_o(a_stb), .we_o(a_we), .wstrb_o(a_be), .addr_o(a_addr),
        .data_o(a_data), .data_i(din), .ack_i(ack), .err_i(err), .busy_o(a_busy),
        .timeout_o(a_tmo));

    obi_wb_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4), .REG_RESP(1'b0)) u_b (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req), .gnt_o(b_gnt), .addr_i(addr), .we_i(we),
        .be_i(be), .wdata_i(wdata), .rvalid_o(b_rv), .rdata_o(b_rdata), .err_o(b_err),
        .cyc_o(b_cyc), .stb_o(b_stb), .we_o(b_we), .wstrb_o(b_be), .addr_o(b_addr),
        .data_o(b_data), .data_i(din), .ack_i(ack), .err_i(err), .busy_o(b_busy),
        .timeout_o(b_tmo));

    typedef struct {
        logic        req, we, ack, err;
        logic [3:0]  be;
        logic [31:0] addr, wdata, din;
        logic        e_gnt, e_cyc, e_rv, e_err, e_tmo;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NV = 24;
    localparam logic [31:0] J = 32'h9999_9999;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic rq, w, input logic [3:0] b,
                                input logic [31:0] a, wd, input logic ak, er,
                                input logic [31:0] d, input logic g, c, rv, e, t,
                                input logic [31:0] rd);
        vec_t v;
        v.req = rq; v.we = w; v.be = b; v.addr = a; v.wdata = wd;
        v.ack = ak; v.err = er; v.din = d;
        v.e_gnt = g; v.e_cyc = c; v.e_rv = rv; v.e_err = e; v.e_tmo = t; v.e_rdata = rd;
        return v;
    endfunction

    task automatic drive(input logic rq, w, input logic [3:0] b, input logic [31:0] a, wd,
                         input logic ak, er, input logic [31:0] d);
        req = rq; we = w; be = b; addr = a; wdata = wd; ack = ak; err = er; din = d;
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] ea, ew;
    logic [3:0]  eb;
    logic        ewe;

    initial begin
        // read / write / 3 wait states / ack+err / timeout with late ack
        tbl[0]  = mk(0,0,4'h0,0,0,0,0,0,                  0,0,0,0,0,0);
        tbl[1]  = mk(1,0,4'hF,32'h10,J,0,0,0,             1,0,0,0,0,0);
        tbl[2]  = mk(0,1,4'h0,J,J,1,0,32'hDEADBEEF,       0,1,0,0,0,0);
        tbl[3]  = mk(0,0,4'h0,0,0,0,0,0,                  0,0,1,0,0,32'hDEADBEEF);
        tbl[4]  = mk(0,0,4'h0,0,0,0,0,0,                  0,0,0,0,0,0);
        tbl[5]  = mk(1,1,4'b0011,32'h20,32'h12345678,0,0,0, 1,0,0,0,0,0);
        tbl[6]  = mk(0,0,4'h0,J,J,1,0,32'hFFFFFFFF,       0,1,0,0,0,0);
        tbl[7]  = mk(0,0,4'h0,0,0,0,0,0,                  0,0,1,0,0,0);
        tbl[8]  = mk(1,0,4'hF,32'h40,J,0,0,0,             1,0,0,0,0,0);
        tbl[9]  = mk(1,1,4'h1,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[10] = mk(1,1,4'h1,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[11] = mk(1,1,4'h1,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[12] = mk(1,1,4'h1,J,J,1,0,32'hA5A5A5A5,       0,1,0,0,0,0);
        tbl[13] = mk(1,0,4'hF,32'hCAFE0000,J,0,0,0,       1,0,1,0,0,32'hA5A5A5A5);
        tbl[14] = mk(0,0,4'h0,J,J,1,1,32'h12121212,       0,1,0,0,0,0);
        tbl[15] = mk(0,0,4'h0,0,0,0,0,0,                  0,0,1,1,0,0);
        tbl[16] = mk(1,0,4'hF,32'h80,J,0,0,0,             1,0,0,0,0,0);
        tbl[17] = mk(0,0,4'h0,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[18] = mk(0,0,4'h0,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[19] = mk(0,0,4'h0,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[20] = mk(0,0,4'h0,J,J,0,0,0,                  0,1,0,0,0,0);
        tbl[21] = mk(0,0,4'h0,0,0,1,0,32'h55555555,       0,0,1,1,1,0);
        tbl[22] = mk(0,0,4'h0,0,0,1,0,32'h55555555,       0,0,0,0,0,0);
        tbl[23] = mk(0,0,4'h0,0,0,0,0,0,                  0,0,0,0,0,0);
        ea = '0; ew = '0; eb = '0; ewe = 1'b0;

        // reset state, with a pending request that must not be granted
        rst_ni = 1'b0;
        drive(1,0,4'hF,32'h10,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;
        chk1("rst.gnt", a_gnt, 1'b0);
        chk1("rst.cyc", a_cyc, 1'b0);
        chk1("rst.busy", a_busy, 1'b0);
        chk1("rst.rvalid", a_rv, 1'b0);
        chk1("rst.tmo", a_tmo, 1'b0);
        chk32("rst.addr", a_addr, 32'h0);
        chk1("rst.b_gnt", b_gnt, 1'b0);
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            next_cycle();
            drive(tbl[i].req, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata,
                  tbl[i].ack, tbl[i].err, tbl[i].din);
            @(negedge clk);
            chk1($sformatf("v%0d.gnt", i), a_gnt, tbl[i].e_gnt);
            chk1($sformatf("v%0d.cyc", i), a_cyc, tbl[i].e_cyc);
            chk1($sformatf("v%0d.stb", i), a_stb, tbl[i].e_cyc);
            chk1($sformatf("v%0d.busy", i), a_busy, tbl[i].e_cyc | tbl[i].e_rv);
            chk1($sformatf("v%0d.rvalid", i), a_rv, tbl[i].e_rv);
            chk1($sformatf("v%0d.err", i), a_err, tbl[i].e_err);
            chk1($sformatf("v%0d.tmo", i), a_tmo, tbl[i].e_tmo);
            chk32($sformatf("v%0d.rdata", i), a_rdata, tbl[i].e_rdata);
            chk32($sformatf("v%0d.addr_o", i), a_addr, tbl[i].e_cyc ? ea : 32'h0);
            chk32($sformatf("v%0d.data_o", i), a_data, tbl[i].e_cyc ? ew : 32'h0);
            chk32($sformatf("v%0d.wstrb", i), 32'(a_be), tbl[i].e_cyc ? 32'(eb) : 32'h0);
            chk1($sformatf("v%0d.we_o", i), a_we, tbl[i].e_cyc ? ewe : 1'b0);
            if (tbl[i].e_gnt) begin
                ea = tbl[i].addr; ew = tbl[i].wdata; eb = tbl[i].be; ewe = tbl[i].we;
            end
        end

        // async reset while both instances are in BUS
        next_cycle();
        drive(1,0,4'hF,32'h100,0,0,0,0);
        next_cycle();
        #1;
        chk1("mid.cyc_before", a_cyc, 1'b1);
        rst_ni = 1'b0;
        #1;
        chk1("mid.cyc", a_cyc, 1'b0);
        chk1("mid.busy", a_busy, 1'b0);
        chk1("mid.rvalid", a_rv, 1'b0);
        chk1("mid.gnt", a_gnt, 1'b0);
        chk1("mid.b_cyc", b_cyc, 1'b0);
        next_cycle();
        drive(1,0,4'hF,32'h100,0,1,0,32'h11111111);
        next_cycle();
        rst_ni = 1'b1;
        drive(0,0,4'hF,0,0,1,0,32'h11111111);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1($sformatf("post%0d.rvalid", k), a_rv, 1'b0);
            chk1($sformatf("post%0d.b_rvalid", k), b_rv, 1'b0);
            next_cycle();
        end
        drive(1,0,4'hF,32'h200,0,0,0,0);
        @(negedge clk);
        chk1("post.gnt", a_gnt, 1'b1);
        chk1("post.b_gnt", b_gnt, 1'b1);

        // same-cycle response read; grant blocked in the termination cycle
        next_cycle();
        drive(1,0,4'hF,J,0,1,0,32'h0BADF00D);
        @(negedge clk);
        chk1("p.cyc", a_cyc, 1'b1);
        chk32("p.addr", a_addr, 32'h200);
        chk1("p.a_rvalid", a_rv, 1'b0);
        chk1("b.rd.rvalid", b_rv, 1'b1);
        chk32("b.rd.rdata", b_rdata, 32'h0BADF00D);
        chk1("b.rd.err", b_err, 1'b0);
        chk1("b.rd.gnt", b_gnt, 1'b0);
        next_cycle();
        drive(0,0,4'hF,0,0,0,0,0);
        @(negedge clk);
        chk1("p.rvalid", a_rv, 1'b1);
        chk32("p.rdata", a_rdata, 32'h0BADF00D);
        chk1("b.rd.idle_rv", b_rv, 1'b0);
        chk1("b.rd.idle_busy", b_busy, 1'b0);

        // same-cycle response write, then error
        next_cycle();
        drive(1,1,4'b1100,32'h300,32'hCAFEF00D,0,0,0);
        @(negedge clk);
        chk1("b.wr.gnt", b_gnt, 1'b1);
        next_cycle();
        drive(0,0,0,J,J,1,0,32'h33333333);
        @(negedge clk);
        chk1("b.wr.we_o", b_we, 1'b1);
        chk32("b.wr.wstrb", 32'(b_be), 32'hC);
        chk32("b.wr.data_o", b_data, 32'hCAFEF00D);
        chk1("b.wr.rvalid", b_rv, 1'b1);
        chk32("b.wr.rdata", b_rdata, 32'h0);
        next_cycle();
        drive(1,0,4'hF,32'h400,0,0,0,0);
        @(negedge clk);
        chk1("b.er.gnt", b_gnt, 1'b1);
        next_cycle();
        drive(0,0,0,0,0,0,1,32'h77777777);
        @(negedge clk);
        chk1("b.er.rvalid", b_rv, 1'b1);
        chk1("b.er.err", b_err, 1'b1);
        chk32("b.er.rdata", b_rdata, 32'h0);
        next_cycle();
        drive(0,0,0,0,0,0,0,0);
        @(negedge clk);
        chk1("b.er.after", b_rv, 1'b0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/obi_wb_bridge.md
# obi_wb_bridge

Parametrised single-outstanding bridge from the core's request/grant/rvalid memory port (instruction or data side) to a Wishbone-classic master port toward the Controller memory. It passes byte enables through, returns a response for writes as well as reads, forwards bus errors, and aborts hung transfers with a configurable timeout. Registered-response or same-cycle-response behaviour is selected by parameter. One instance sits on each core memory port inside `processorci_top`.

## Interface
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width; must be a multiple of 8. `BE_W = DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, 255: number of BUS cycles without `ack_i`/`err_i` before abort. A value of 0 disables the timeout. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- `REG_RESP`, 1: 1 = response registered (one extra cycle); 0 = response in the same cycle as `ack_i`/`err_i`.

Ports:
- `clk_i`  in  1  core clock; single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `req_i`  in  1  core request.
- `gnt_o`  out  1  request accepted this cycle.
- `addr_i`  in  ADDR_WIDTH  request address.
- `we_i`  in  1  1 = write.
- `be_i`  in  BE_W  byte enables.
- `wdata_i`  in  DATA_WIDTH  write data.
- `rvalid_o`  out  1  one-cycle response strobe, for reads and writes.
- `rdata_o`  out  DATA_WIDTH  read data; 0 for writes and for errors.
- `err_o`  out  1  error qualifier, valid with `rvalid_o`.
- `cyc_o`, `stb_o`  out  1  Wishbone cycle/strobe; identical.
- `we_o`  out  1  Wishbone write enable.
- `wstrb_o`  out  BE_W  Wishbone select.
- `addr_o`  out  ADDR_WIDTH  Wishbone address.
- `data_o`  out  DATA_WIDTH  Wishbone write data.
- `data_i`  in  DATA_WIDTH  Wishbone read data.
- `ack_i`, `err_i`  in  1  Wishbone termination.
- `busy_o`  out  1  high in every state other than IDLE.
- `timeout_o`  out  1  one-cycle pulse when a transfer is aborted by the timeout.

## Operation
- States: IDLE, BUS, RESP. RESP is used when `REG_RESP=1` and for every timeout abort.
- **Grant:** `gnt_o = req_i` in IDLE and RESP, and 0 in BUS.
  - On a grant edge, `addr_i`, `we_i`, `be_i` and `wdata_i` are captured into registers.
  - The state moves to BUS.
  - The timeout counter is cleared.
- **BUS:**
  - `cyc_o`, `stb_o`, `we_o`, `wstrb_o`, `addr_o` and `data_o` are driven from the captured registers and held stable until termination.
  - The timeout counter increments each cycle that has neither `ack_i` nor `err_i`.
- **Termination on `ack_i | err_i` in BUS:**
  - `REG_RESP=1`: capture `data_i` (reads only) and the error flag, then go to RESP. RESP drives `rvalid_o=1` from the captured values, then moves to IDLE, or to BUS if a new request is granted that cycle.
  - `REG_RESP=0`: `rvalid_o=1` in the same cycle, with `rdata_o = we ? 0 : data_i` and `err_o = err_i`. Next state is IDLE. No grant is issued in that cycle.
- **Simultaneous `ack_i` and `err_i`:** error wins. `err_o=1` and `rdata_o=0`.
- **Timeout:** when the counter reaches `TIMEOUT_CYCLES` while still in BUS with no termination:
  - `cyc_o`/`stb_o` drop at the next edge.
  - The state moves to RESP with `err_o=1` and `rdata_o=0`.
  - `timeout_o` pulses in the RESP cycle.
  - A late `ack_i` after the abort is ignored.
- **`ack_i`/`err_i` outside BUS** are ignored.
- **Response ordering:** exactly one `rvalid_o` is produced per grant, in grant order. Only one transfer is outstanding at a time.

## Timing
- **Reset (asynchronous):**
  - State goes to IDLE; every registered output goes to 0.
  - `gnt_o` is forced to 0 while `rst_ni=0`.
  - Any in-flight transfer is dropped with no response.
- **Latency from the grant edge to `rvalid_o`**, with `ack_i` returned in the first BUS cycle:
  - `REG_RESP=1`: 2 cycles.
  - `REG_RESP=0`: 1 cycle.
- **Throughput (zero-wait slave):**
  - `REG_RESP=1`: back-to-back grants every 2 cycles (grant in RESP).
  - `REG_RESP=0`: every 2 cycles (BUS, then IDLE).
- **Abort timing:** with `TIMEOUT_CYCLES=N`, a silent slave sees `cyc_o` high for exactly N cycles. `rvalid_o` and `err_o` then assert in the following cycle.
- **Counter width:** the counter saturates at `TIMEOUT_CYCLES` and never wraps.

## Test plan
- **Read, `REG_RESP=1`, zero-wait slave:** read `0x0000_0010` returning `0xDEAD_BEEF`.
  - Required: grant at cycle 0; `cyc_o=1` and `addr_o=0x10` at cycle 1; `rvalid_o=1`, `rdata_o=0xDEADBEEF`, `err_o=0` at cycle 2.
- **Write with `be_i=4'b0011`, `wdata_i=0x1234_5678`:**
  - Required: `we_o=1`, `wstrb_o=0011`, `data_o=0x12345678` during BUS; `rvalid_o` pulses once with `rdata_o=0`.
- **Slave with 3 wait states:**
  - Required: `cyc_o` stays high 4 cycles with `addr_o`/`data_o` stable; `gnt_o=0` throughout BUS even though `req_i` is held high.
- **Timeout:** `TIMEOUT_CYCLES=4`, slave never acks.
  - Required: `cyc_o` is high for exactly 4 cycles; then `rvalid_o=1`, `err_o=1`, `timeout_o=1` for one cycle.
  - A later `ack_i` produces no response.
- **Error conditions:**
  - `ack_i` and `err_i` asserted together on a read of `0xCAFE_0000`: required `err_o=1`, `rdata_o=0`.
  - `REG_RESP=0` read: `rvalid_o` is high in the same cycle as `ack_i`.
- **Reset mid-transfer:** drop `rst_ni` while in BUS.
  - Required: `cyc_o`, `busy_o` and `rvalid_o` go to 0 immediately; no `rvalid_o` after release; the next request is granted normally.
